snake_body_trail: RTL and testbench

Downstream stage of the snake head-movement block. Records each committed head position in a circular history buffer, keeps the current body length, answers per-pixel "is this pixel body?" queries for the drawing path, and flags head-into-body self-collision. Sits between the head mover and the pixel mux / game-control logic.

---
 rtl/snake_body_trail.sv | 143 ++++++++++++++
 tb/tb_snake_body_trail.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_trail.sv
// Circular history of committed snake head cells: body length, per-pixel body query, self-collision.
// Optional macro SNAKE_TRAIL_SELF_HIT_EN builds the head-vs-body comparators; otherwise self_hit is 0.
module snake_body_trail #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 4,
    parameter int SEG_SIZE = 32
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      clear,
    input  logic                      head_step,
    input  logic                      grow,
    input  logic [10:0]               head_x,
    input  logic [10:0]               head_y,
    input  logic [10:0]               pixel_x,
    input  logic [10:0]               pixel_y,
    output logic                      body_hit,
    output logic                      self_hit,
    output logic [$clog2(MAX_LEN):0]  length
);

    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] INIT_L = LEN_W'(INIT_LEN);
    localparam logic [11:0]      SEG_W  = 12'(SEG_SIZE);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic             body_hit_q, body_hit_d;

    logic [10:0] mem_x_q [MAX_LEN];
    logic [10:0] mem_y_q [MAX_LEN];

    logic [LEN_W-1:0]   active_lim;
    logic [LEN_W-1:0]   grown_len;
    logic               step_en;
    logic [MAX_LEN-1:0] active;
    logic [MAX_LEN-1:0] in_box;

    assign step_en    = head_step && !clear;
    assign active_lim = (fill_q < length_q) ? fill_q : length_q;
    assign grown_len  = (grow && (length_q != MAX_L)) ? length_q + LEN_W'(1) : length_q;

    // Position storage carries no reset; entries are only read once covered by fill.
    always_ff @(posedge clk) begin
        if (step_en) begin
            mem_x_q[wr_ptr_q] <= head_x;
            mem_y_q[wr_ptr_q] <= head_y;
        end
    end

`ifdef SNAKE_TRAIL_SELF_HIT_EN
    logic [LEN_W-1:0]   keep_lim;
    logic [MAX_LEN-1:0] head_eq;
    logic [MAX_LEN-1:0] before_tail;

    // The tail entry vacates on this step, so only ages below (new length - 1) can collide.
    assign keep_lim = grown_len - LEN_W'(1);
`endif

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_entry
        logic [PTR_W-1:0] age;
        logic [11:0]      ex;
        logic [11:0]      ey;

        assign age       = wr_ptr_q - PTR_W'(1) - PTR_W'(g);
        assign ex        = {1'b0, mem_x_q[g]};
        assign ey        = {1'b0, mem_y_q[g]};
        assign active[g] = {1'b0, age} < active_lim;
        assign in_box[g] = (ex <= {1'b0, pixel_x}) && ({1'b0, pixel_x} < ex + SEG_W) &&
                           (ey <= {1'b0, pixel_y}) && ({1'b0, pixel_y} < ey + SEG_W);
`ifdef SNAKE_TRAIL_SELF_HIT_EN
        assign head_eq[g]     = (mem_x_q[g] == head_x) && (mem_y_q[g] == head_y);
        assign before_tail[g] = {1'b0, age} < keep_lim;
`endif
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        length_d   = length_q;
        body_hit_d = |(active & in_box);
        if (clear) begin
            wr_ptr_d   = '0;
            fill_d     = '0;
            length_d   = INIT_L;
            body_hit_d = 1'b0;
        end else begin
            length_d = grown_len;
            if (head_step) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (fill_q != MAX_L) begin
                    fill_d = fill_q + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            length_q   <= INIT_L;
            body_hit_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            length_q   <= length_d;
            body_hit_q <= body_hit_d;
        end
    end

`ifdef SNAKE_TRAIL_SELF_HIT_EN
    logic self_hit_q, self_hit_d;

    always_comb begin
        self_hit_d = self_hit_q;
        if (clear) begin
            self_hit_d = 1'b0;
        end else if (head_step && |(active & before_tail & head_eq)) begin
            self_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            self_hit_q <= 1'b0;
        end else begin
            self_hit_q <= self_hit_d;
        end
    end

    assign self_hit = self_hit_q;
`else
    assign self_hit = 1'b0;
`endif

    assign body_hit = body_hit_q;
    assign length   = length_q;

endmodule

// File: tb/tb_snake_body_trail.sv
// Randomized and directed bench for snake_body_trail against a queue-based history model.
module tb_snake_body_trail;

    localparam int MAX_LEN  = 32;
    localparam int INIT_LEN = 4;
    localparam int SEG_SIZE = 32;
`ifdef SNAKE_TRAIL_SELF_HIT_EN
    localparam bit SELF_EN = 1'b1;
`else
    localparam bit SELF_EN = 1'b0;
`endif

    logic        clk, resetN, clear, head_step, grow;
    logic [10:0] head_x, head_y, pixel_x, pixel_y;
    logic        body_hit, self_hit;
    logic [5:0]  length;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: list of committed heads (oldest first), current length, flags
    int hist_x[$];
    int hist_y[$];
    int m_len;
    bit m_self;
    bit m_body;

    snake_body_trail #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .SEG_SIZE(SEG_SIZE)) dut (
        .clk(clk), .resetN(resetN), .clear(clear), .head_step(head_step), .grow(grow),
        .head_x(head_x), .head_y(head_y), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .body_hit(body_hit), .self_hit(self_hit), .length(length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        hist_x.delete();
        hist_y.delete();
        m_len  = INIT_LEN;
        m_self = 1'b0;
        m_body = 1'b0;
    endfunction

    // the body is the newest min(written, length) heads
    function automatic bit model_body(int px, int py);
        int n;
        n = min2(hist_x.size(), m_len);
        for (int k = 0; k < n; k++) begin
            int ex, ey;
            ex = hist_x[hist_x.size() - 1 - k];
            ey = hist_y[hist_y.size() - 1 - k];
            if (px >= ex && px < ex + SEG_SIZE && py >= ey && py < ey + SEG_SIZE) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_cycle(bit st, bit gr, bit cl, int hx, int hy, int px, int py);
        int new_len, n;
        if (cl) begin
            model_reset();
            return;
        end
        m_body  = model_body(px, py);
        new_len = (gr && m_len < MAX_LEN) ? m_len + 1 : m_len;
        if (st) begin
            n = min2(min2(hist_x.size(), m_len), new_len - 1);
            for (int k = 0; k < n; k++) begin
                if (hist_x[hist_x.size() - 1 - k] == hx && hist_y[hist_y.size() - 1 - k] == hy && SELF_EN)
                    m_self = 1'b1;
            end
            hist_x.push_back(hx);
            hist_y.push_back(hy);
            if (hist_x.size() > MAX_LEN) begin
                void'(hist_x.pop_front());
                void'(hist_y.pop_front());
            end
        end
        m_len = new_len;
    endfunction

    task automatic cycle(input bit st, input bit gr, input bit cl,
                         input int hx, input int hy, input int px, input int py);
        @(negedge clk);
        head_step = st;
        grow      = gr;
        clear     = cl;
        head_x    = 11'(hx);
        head_y    = 11'(hy);
        pixel_x   = 11'(px);
        pixel_y   = 11'(py);
        model_cycle(st, gr, cl, hx, hy, px, py);
        @(posedge clk);
        #1;
        head_step = 1'b0;
        grow      = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL reset_body_hit got=%b exp=0", body_hit); end
        n_tests++; if (self_hit !== 1'b0) begin n_fail++; $display("FAIL reset_self_hit got=%b exp=0", self_hit); end
        n_tests++; if (length !== 6'(INIT_LEN)) begin n_fail++; $display("FAIL reset_length got=%0d exp=%0d", length, INIT_LEN); end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 5; k++) cycle(1, 0, 0, 32 * k, 32, 2000, 2000);
        n_tests++; if (length !== 6'd4) begin n_fail++; $display("FAIL basic_length got=%0d exp=4", length); end
        cycle(0, 0, 0, 0, 0, 40, 40);
        n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL basic_dropped_oldest got=%b exp=0", body_hit); end
        cycle(0, 0, 0, 0, 0, 170, 50);
        n_tests++; if (body_hit !== 1'b1) begin n_fail++; $display("FAIL basic_newest got=%b exp=1", body_hit); end
    endtask

    task automatic test_back_to_back();
        cycle(1, 0, 0, 500, 500, 510, 510);
        n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL b2b_coincident_write got=%b exp=0", body_hit); end
        cycle(1, 0, 0, 532, 500, 510, 510);
        n_tests++; if (body_hit !== 1'b1) begin n_fail++; $display("FAIL b2b_prev_write got=%b exp=1", body_hit); end
        cycle(0, 0, 0, 0, 0, 563, 531);
        n_tests++; if (body_hit !== m_body) begin n_fail++; $display("FAIL b2b_corner got=%b exp=%b", body_hit, m_body); end
        n_tests++; if (length !== 6'(m_len)) begin n_fail++; $display("FAIL b2b_length got=%0d exp=%0d", length, m_len); end
    endtask

    task automatic test_grow();
        for (int k = 0; k < 29; k++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            n_tests++; if (length !== 6'(m_len)) begin n_fail++; $display("FAIL grow_step%0d got=%0d exp=%0d", k, length, m_len); end
        end
        n_tests++; if (length !== 6'd32) begin n_fail++; $display("FAIL grow_saturate got=%0d exp=32", length); end
    endtask

    task automatic test_collision();
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 32, 32, 0, 0);
        cycle(1, 0, 0, 64, 32, 0, 0);
        cycle(1, 0, 0, 64, 64, 0, 0);
        cycle(1, 0, 0, 32, 64, 0, 0);
        cycle(1, 0, 0, 32, 32, 0, 0);
        n_tests++; if (self_hit !== 1'b0) begin n_fail++; $display("FAIL coll_tail_vacated got=%b exp=0", self_hit); end
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 32, 32, 0, 0);
        cycle(1, 0, 0, 64, 32, 0, 0);
        cycle(1, 0, 0, 64, 64, 0, 0);
        cycle(1, 0, 0, 32, 64, 0, 0);
        cycle(1, 1, 0, 32, 32, 0, 0);
        n_tests++; if (self_hit !== SELF_EN) begin n_fail++; $display("FAIL coll_with_grow got=%b exp=%b", self_hit, SELF_EN); end
        n_tests++; if (length !== 6'd5) begin n_fail++; $display("FAIL coll_length got=%0d exp=5", length); end
        cycle(0, 0, 0, 0, 0, 0, 0);
        n_tests++; if (self_hit !== SELF_EN) begin n_fail++; $display("FAIL coll_sticky got=%b exp=%b", self_hit, SELF_EN); end
    endtask

    task automatic test_clear_priority();
        cycle(0, 0, 0, 0, 0, 40, 40);
        n_tests++; if (body_hit !== 1'b1) begin n_fail++; $display("FAIL clr_pre_body got=%b exp=1", body_hit); end
        cycle(1, 1, 1, 32, 32, 40, 40);
        n_tests++; if (self_hit !== 1'b0) begin n_fail++; $display("FAIL clr_self_hit got=%b exp=0", self_hit); end
        n_tests++; if (length !== 6'(INIT_LEN)) begin n_fail++; $display("FAIL clr_length got=%0d exp=%0d", length, INIT_LEN); end
        n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL clr_body_hit got=%b exp=0", body_hit); end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0, 32 + 8 * k, 32 + 8 * k);
            n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL clr_empty_q%0d got=%b exp=0", k, body_hit); end
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 28; k++) cycle(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 40; k++) cycle(1, 0, 0, 32 * k, 64, 0, 0);
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0, 0, 0, 0, 32 * k + 5, 70);
            n_tests++;
            if (body_hit !== ((k >= 8) ? 1'b1 : 1'b0) || body_hit !== m_body) begin
                n_fail++; $display("FAIL wrap_pos%0d got=%b model=%b", k, body_hit, m_body);
            end
        end
        cycle(0, 0, 0, 0, 0, 255, 64);
        n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL wrap_edge_old got=%b exp=0", body_hit); end
        cycle(0, 0, 0, 0, 0, 256, 95);
        n_tests++; if (body_hit !== 1'b1) begin n_fail++; $display("FAIL wrap_edge_new got=%b exp=1", body_hit); end
        cycle(0, 0, 0, 0, 0, 256, 96);
        n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL wrap_edge_y got=%b exp=0", body_hit); end
    endtask

    task automatic test_random();
        cycle(0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            bit st, gr, cl;
            st = ($urandom_range(1) == 0);
            gr = ($urandom_range(7) == 0);
            cl = ($urandom_range(99) == 0);
            cycle(st, gr, cl, 32 * $urandom_range(3), 32 * $urandom_range(3),
                  $urandom_range(170), $urandom_range(170));
            n_tests++; if (body_hit !== m_body) begin n_fail++; $display("FAIL rand_body c%0d got=%b exp=%b", k, body_hit, m_body); end
            n_tests++; if (self_hit !== m_self) begin n_fail++; $display("FAIL rand_self c%0d got=%b exp=%b", k, self_hit, m_self); end
            n_tests++; if (length !== 6'(m_len)) begin n_fail++; $display("FAIL rand_len c%0d got=%0d exp=%0d", k, length, m_len); end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 6; k++) cycle(1, 1, 0, 32 * k, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 10, 10);
        n_tests++; if (body_hit !== 1'b1) begin n_fail++; $display("FAIL arst_pre_body got=%b exp=1", body_hit); end
        @(negedge clk);
        #1;
        resetN = 1'b0;
        #1;
        model_reset();
        n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL arst_body_hit got=%b exp=0", body_hit); end
        n_tests++; if (self_hit !== 1'b0) begin n_fail++; $display("FAIL arst_self_hit got=%b exp=0", self_hit); end
        n_tests++; if (length !== 6'(INIT_LEN)) begin n_fail++; $display("FAIL arst_length got=%0d exp=%0d", length, INIT_LEN); end
        @(negedge clk);
        resetN = 1'b1;
        cycle(1, 0, 0, 300, 300, 10, 10);
        n_tests++; if (body_hit !== 1'b0) begin n_fail++; $display("FAIL arst_post_body got=%b exp=0", body_hit); end
        cycle(0, 0, 0, 0, 0, 310, 310);
        n_tests++; if (body_hit !== 1'b1) begin n_fail++; $display("FAIL arst_resume got=%b exp=1", body_hit); end
    endtask

    initial begin
        resetN    = 1'b0;
        clear     = 1'b0;
        head_step = 1'b0;
        grow      = 1'b0;
        head_x    = '0;
        head_y    = '0;
        pixel_x   = '0;
        pixel_y   = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_grow();
        test_collision();
        test_clear_priority();
        test_wrap();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
